// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search used by the AXI-Stream packet arbiter
// and by any later scheduler that needs the same fairness rule.
`timescale 1ns/1ps
package axis_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_PASS = 1'b1
  } arb_state_t;

  localparam int MAX_INPUTS = 16;

  // First set request bit searching upward from last+1, wrapping at n.
  // Returns 0 when nothing is requested; callers qualify with |req.
  function automatic int rr_next(
    input logic [MAX_INPUTS-1:0] req,
    input int                    last,
    input int                    n
  );
    int         winner;
    logic       found;
    logic [3:0] idx;
    winner = 0;
    found  = 1'b0;
    for (int i = 1; i <= MAX_INPUTS; i++) begin
      idx = 4'((last + i) % n);
      if (!found && (i <= n) && req[idx]) begin
        winner = int'(idx);
        found  = 1'b1;
      end
    end
    return winner;
  endfunction

endpackage

// File: rtl/axis_arb_mux_rr_select.sv
// Combinational round-robin priority selector: picks the next requester after
// the most recent owner, wrapping around the request vector.
`timescale 1ns/1ps
module rr_select #(
  parameter int N        = 2,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic [N-1:0]        i_req,
  input  logic [IDX_BITS-1:0] i_last,
  output logic [IDX_BITS-1:0] o_winner,
  output logic                o_any_req
);
  import axis_arb_pkg::*;

  logic [MAX_INPUTS-1:0] w_req_ext;

  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = i_req;
    o_winner         = IDX_BITS'(rr_next(w_req_ext, int'(i_last), N));
    o_any_req        = |i_req;
  end

endmodule

// File: rtl/axis_arb_mux.sv
// Packet-atomic round-robin AXI-Stream arbiter feeding one registered output
// beat; an owner keeps the output until its tlast beat has been accepted.
`timescale 1ns/1ps
module axis_arb_mux #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_INPUTS     = 2,
  parameter int IDX_BITS       = $clog2(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic [NUM_INPUTS-1:0]                axis_i_tvalid,
  output logic [NUM_INPUTS-1:0]                axis_i_tready,
  input  logic [NUM_INPUTS*8*AXIS_BYTES-1:0]   axis_i_tdata,
  input  logic [NUM_INPUTS*AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic [NUM_INPUTS*AXIS_BYTES-1:0]     axis_i_tkeep,
  input  logic [NUM_INPUTS-1:0]                axis_i_tlast,
  output logic                                 axis_o_tvalid,
  input  logic                                 axis_o_tready,
  output logic [8*AXIS_BYTES-1:0]              axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]            axis_o_tuser,
  output logic [AXIS_BYTES-1:0]                axis_o_tkeep,
  output logic                                 axis_o_tlast,
  output logic [IDX_BITS-1:0]                  grant_idx,
  output logic                                 busy
);
  import axis_arb_pkg::*;

  localparam int DW = 8 * AXIS_BYTES;
  localparam int UW = AXIS_USER_BITS;
  localparam int KW = AXIS_BYTES;

  arb_state_t          r_state;
  logic [IDX_BITS-1:0] r_last_grant;
  logic [IDX_BITS-1:0] r_grant_idx;
  logic                r_busy;
  logic                r_o_tvalid;
  logic [DW-1:0]       r_o_tdata;
  logic [UW-1:0]       r_o_tuser;
  logic [KW-1:0]       r_o_tkeep;
  logic                r_o_tlast;

  logic [IDX_BITS-1:0]   w_winner;
  logic                  w_any_req;
  logic                  w_slot_ready;
  logic                  w_accept;
  logic [NUM_INPUTS-1:0] w_tready;
  logic                  w_sel_tvalid;
  logic                  w_sel_tlast;
  logic [DW-1:0]         w_sel_tdata;
  logic [UW-1:0]         w_sel_tuser;
  logic [KW-1:0]         w_sel_tkeep;

  rr_select #(
    .N        (NUM_INPUTS),
    .IDX_BITS (IDX_BITS)
  ) u_rr_select (
    .i_req     (axis_i_tvalid),
    .i_last    (r_last_grant),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  // Granted-slice multiplexer.
  always_comb begin
    w_sel_tvalid = axis_i_tvalid[r_grant_idx];
    w_sel_tlast  = axis_i_tlast[r_grant_idx];
    w_sel_tdata  = axis_i_tdata[int'(r_grant_idx)*DW +: DW];
    w_sel_tuser  = axis_i_tuser[int'(r_grant_idx)*UW +: UW];
    w_sel_tkeep  = axis_i_tkeep[int'(r_grant_idx)*KW +: KW];
  end

  // The output slot can take a beat when empty or being drained this cycle.
  always_comb begin
    w_slot_ready = !r_o_tvalid || axis_o_tready;
    w_tready     = '0;
    if (r_state == ARB_PASS) begin
      w_tready[r_grant_idx] = w_slot_ready;
    end else begin
      w_tready = '0;
    end
    w_accept = (r_state == ARB_PASS) && w_sel_tvalid && w_slot_ready;
  end

  // Arbitration state machine together with the one-beat output register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= IDX_BITS'(NUM_INPUTS - 1);
      r_grant_idx  <= '0;
      r_busy       <= 1'b0;
      r_o_tvalid   <= 1'b0;
      r_o_tdata    <= '0;
      r_o_tuser    <= '0;
      r_o_tkeep    <= '0;
      r_o_tlast    <= 1'b0;
    end else begin
      if (axis_o_tready) begin
        r_o_tvalid <= 1'b0;
      end
      // A new beat overrides the drain of the previous one.
      if (w_accept) begin
        r_o_tvalid <= 1'b1;
        r_o_tdata  <= w_sel_tdata;
        r_o_tuser  <= w_sel_tuser;
        r_o_tkeep  <= w_sel_tkeep;
        r_o_tlast  <= w_sel_tlast;
      end
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_grant_idx <= w_winner;
            r_busy      <= 1'b1;
            r_state     <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (w_accept && w_sel_tlast) begin
            r_last_grant <= r_grant_idx;
            r_busy       <= 1'b0;
            r_state      <= ARB_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign axis_i_tready = w_tready;
  assign axis_o_tvalid = r_o_tvalid;
  assign axis_o_tdata  = r_o_tdata;
  assign axis_o_tuser  = r_o_tuser;
  assign axis_o_tkeep  = r_o_tkeep;
  assign axis_o_tlast  = r_o_tlast;
  assign grant_idx     = r_grant_idx;
  assign busy          = r_busy;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Directed bench for the three-input arbiter: latency, round-robin order,
// downstream stall, mid-packet gaps, asynchronous reset and full-rate alternation.
`timescale 1ns/1ps
module tb_axis_arb_mux;

  logic        clk;
  logic        aresetn;
  logic [2:0]  tvalid;
  logic [2:0]  tready;
  logic [23:0] tdata;
  logic [5:0]  tuser;
  logic [2:0]  tkeep;
  logic [2:0]  tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic [7:0]  o_tdata;
  logic [1:0]  o_tuser;
  logic [0:0]  o_tkeep;
  logic        o_tlast;
  logic [1:0]  grant_idx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axis_arb_mux #(
    .AXIS_BYTES     (1),
    .AXIS_USER_BITS (2),
    .NUM_INPUTS     (3)
  ) u_dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .axis_i_tvalid (tvalid),
    .axis_i_tready (tready),
    .axis_i_tdata  (tdata),
    .axis_i_tuser  (tuser),
    .axis_i_tkeep  (tkeep),
    .axis_i_tlast  (tlast),
    .axis_o_tvalid (o_tvalid),
    .axis_o_tready (o_tready),
    .axis_o_tdata  (o_tdata),
    .axis_o_tuser  (o_tuser),
    .axis_o_tkeep  (o_tkeep),
    .axis_o_tlast  (o_tlast),
    .grant_idx     (grant_idx),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic v, input logic [7:0] d, input logic l, input logic [1:0] u);
    tvalid[k]        = v;
    tdata[k*8 +: 8]  = d;
    tlast[k]         = l;
    tuser[k*2 +: 2]  = u;
    tkeep[k]         = 1'b1;
  endtask

  // Free-running sources on the masked inputs; checks output order and spacing.
  task automatic stream(input logic [2:0] mask, input int beats, input int npk, input int order [6]);
    int         beat [3];
    int         sent;
    int         got;
    int         last_cyc;
    int         idx;
    int         b;
    logic [2:0] acc;
    beat     = '{0, 0, 0};
    sent     = 0;
    got      = 0;
    last_cyc = -1;
    o_tready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(k, mask[k], {4'(k), 4'd0}, (beats == 1), 2'(k));
    end
    for (int cyc = 0; cyc < 100 && got < npk * beats; cyc++) begin
      #1;
      acc = tvalid & tready;
      tick();
      if (o_tvalid) begin
        idx = got / beats;
        b   = got % beats;
        chk("stream_tuser", 32'(o_tuser), 32'(order[idx]));
        chk("stream_tdata", 32'(o_tdata), 32'({4'(order[idx]), 4'(b)}));
        chk("stream_tlast", 32'(o_tlast), 32'(b == beats - 1));
        chk("stream_tkeep", 32'(o_tkeep), 32'h1);
        if (beats == 1 && last_cyc >= 0) begin
          chk("stream_gap", 32'(cyc - last_cyc), 32'd2);
        end
        last_cyc = cyc;
        got++;
      end
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) begin
          sent++;
          beat[k] = (beat[k] + 1) % beats;
        end
      end
      for (int k = 0; k < 3; k++) begin
        drive(k, mask[k] && (sent < npk * beats), {4'(k), 4'(beat[k])}, (beat[k] == beats - 1), 2'(k));
      end
    end
    chk("stream_count", 32'(got), 32'(npk * beats));
    for (int k = 0; k < 3; k++) begin
      drive(k, 1'b0, 8'h00, 1'b0, 2'd0);
    end
    tick();
  endtask

  initial begin
    aresetn  = 1'b0;
    o_tready = 1'b1;
    tvalid   = 3'b000;
    tdata    = 24'h0;
    tuser    = 6'h0;
    tkeep    = 3'b000;
    tlast    = 3'b000;

    // Reset state
    repeat (3) tick();
    chk("rst_o_tvalid", 32'(o_tvalid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);
    chk("rst_tready", 32'(tready), 32'h0);
    aresetn = 1'b1;
    tick();

    // Three-beat packet from input 0
    drive(0, 1'b1, 8'h11, 1'b0, 2'd0);
    #1;
    chk("s1_idle_tready", 32'(tready), 32'h0);
    tick();
    chk("s1_busy", 32'(busy), 32'h1);
    chk("s1_grant", 32'(grant_idx), 32'h0);
    chk("s1_tready", 32'(tready), 32'h1);
    chk("s1_o_tvalid_pre", 32'(o_tvalid), 32'h0);
    tick();
    chk("s1_o_tvalid", 32'(o_tvalid), 32'h1);
    chk("s1_beat0", 32'(o_tdata), 32'h11);
    drive(0, 1'b1, 8'h12, 1'b0, 2'd0);
    tick();
    chk("s1_beat1", 32'(o_tdata), 32'h12);
    drive(0, 1'b1, 8'h13, 1'b1, 2'd0);
    tick();
    chk("s1_beat2", 32'(o_tdata), 32'h13);
    chk("s1_tlast", 32'(o_tlast), 32'h1);
    chk("s1_busy_drop", 32'(busy), 32'h0);
    drive(0, 1'b0, 8'h00, 1'b0, 2'd0);
    tick();
    chk("s1_o_tvalid_end", 32'(o_tvalid), 32'h0);

    // Round robin over three inputs, two-beat packets (last owner was 0)
    stream(3'b111, 2, 6, '{1, 2, 0, 1, 2, 0});

    // Downstream stall on input 1
    drive(1, 1'b1, 8'h31, 1'b0, 2'd1);
    tick();
    chk("s3_grant", 32'(grant_idx), 32'h1);
    chk("s3_tready", 32'(tready), 32'h2);
    tick();
    chk("s3_beat0", 32'(o_tdata), 32'h31);
    drive(1, 1'b1, 8'h32, 1'b0, 2'd1);
    o_tready = 1'b0;
    #1;
    chk("s3_stall_tready0", 32'(tready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_stall_valid", 32'(o_tvalid), 32'h1);
      chk("s3_stall_data", 32'(o_tdata), 32'h31);
      chk("s3_stall_tready", 32'(tready), 32'h0);
    end
    o_tready = 1'b1;
    #1;
    chk("s3_resume_tready", 32'(tready), 32'h2);
    tick();
    chk("s3_beat1", 32'(o_tdata), 32'h32);
    drive(1, 1'b1, 8'h33, 1'b1, 2'd1);
    tick();
    chk("s3_beat2", 32'(o_tdata), 32'h33);
    chk("s3_tlast", 32'(o_tlast), 32'h1);
    chk("s3_busy_drop", 32'(busy), 32'h0);
    drive(1, 1'b0, 8'h00, 1'b0, 2'd0);
    tick();

    // Input 0 pauses mid-packet while input 1 waits (last owner was 1)
    drive(0, 1'b1, 8'h41, 1'b0, 2'd0);
    drive(1, 1'b1, 8'h51, 1'b1, 2'd1);
    tick();
    chk("s4_grant0", 32'(grant_idx), 32'h0);
    tick();
    chk("s4_beat0", 32'(o_tdata), 32'h41);
    drive(0, 1'b0, 8'h42, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s4_gap_tready", 32'(tready), 32'h1);
      chk("s4_gap_busy", 32'(busy), 32'h1);
      chk("s4_gap_grant", 32'(grant_idx), 32'h0);
    end
    drive(0, 1'b1, 8'h42, 1'b0, 2'd0);
    tick();
    chk("s4_beat1", 32'(o_tdata), 32'h42);
    drive(0, 1'b1, 8'h43, 1'b1, 2'd0);
    tick();
    chk("s4_beat2", 32'(o_tdata), 32'h43);
    chk("s4_busy_drop", 32'(busy), 32'h0);
    drive(0, 1'b0, 8'h00, 1'b0, 2'd0);
    tick();
    chk("s4_grant1", 32'(grant_idx), 32'h1);
    chk("s4_busy1", 32'(busy), 32'h1);
    tick();
    chk("s4_in1_data", 32'(o_tdata), 32'h51);
    chk("s4_in1_user", 32'(o_tuser), 32'h1);
    chk("s4_in1_last", 32'(o_tlast), 32'h1);
    drive(1, 1'b0, 8'h00, 1'b0, 2'd0);
    tick();

    // Asynchronous reset in the middle of an input-1 packet
    drive(1, 1'b1, 8'h61, 1'b0, 2'd1);
    tick();
    chk("s5_grant1", 32'(grant_idx), 32'h1);
    tick();
    chk("s5_pre_valid", 32'(o_tvalid), 32'h1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(o_tvalid), 32'h0);
    chk("s5_rst_busy", 32'(busy), 32'h0);
    chk("s5_rst_tready", 32'(tready), 32'h0);
    tick();
    drive(0, 1'b1, 8'h70, 1'b1, 2'd0);
    drive(1, 1'b1, 8'h71, 1'b1, 2'd1);
    drive(2, 1'b1, 8'h72, 1'b1, 2'd2);
    aresetn = 1'b1;
    tick();
    chk("s5_first_grant", 32'(grant_idx), 32'h0);
    chk("s5_busy", 32'(busy), 32'h1);
    tick();
    chk("s5_data", 32'(o_tdata), 32'h70);
    for (int k = 0; k < 3; k++) begin
      drive(k, 1'b0, 8'h00, 1'b0, 2'd0);
    end
    tick();

    // Full-rate single-beat packets from inputs 0 and 1 (last owner was 0)
    stream(3'b011, 1, 4, '{1, 0, 1, 0, 0, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
